// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM pipeline stage.
//   Accepts one op from EX, issues at most one request on an SRAM-like data bus
//   using a split address/data handshake (req/addr_ok, then data_ok). It aligns
//   and extends load data and forwards the result to WB through an output register.
//   Misaligned accesses raise ALE without touching the bus. A flush kills the
//   current op. A flush that hits an in-flight request cancels it, and the
//   cancelled response is dropped when it returns.
// Ports:
//   clk, rst           clock (rising edge), asynchronous active-high reset
//   flush              kill current op
//   in_*               EX-side op fields, in_valid/in_ready handshake
//   req*, addr_ok,     data-bus request channel and address handshake
//   data_ok, rdata     data-bus response
//   out_*              WB-side result register, out_valid/out_ready handshake
module mem_access_stage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_pc,
    input  logic                  in_mem_en,
    input  logic                  in_store,
    input  logic                  in_signed,
    input  logic [1:0]            in_size,
    input  logic [ADDR_W-1:0]     in_addr,
    input  logic [DATA_W-1:0]     in_wdata,
    input  logic                  in_gr_we,
    input  logic [4:0]            in_waddr,
    output logic                  req,
    output logic                  req_wr,
    output logic [1:0]            req_size,
    output logic [ADDR_W-1:0]     req_addr,
    output logic [DATA_W/8-1:0]   req_wstrb,
    output logic [DATA_W-1:0]     req_wdata,
    input  logic                  addr_ok,
    input  logic                  data_ok,
    input  logic [DATA_W-1:0]     rdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           out_pc,
    output logic                  out_gr_we,
    output logic [4:0]            out_waddr,
    output logic [DATA_W-1:0]     out_wdata,
    output logic                  out_ale,
    output logic [ADDR_W-1:0]     out_badv
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned OFF_W  = $clog2(STRB_W);
    localparam int unsigned AX_W   = (ADDR_W < DATA_W) ? ADDR_W : DATA_W;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    logic [1:0]          state_q, state_d;
    logic                cancel_q, cancel_d;

    // Op fields captured at accept; they drive the bus and stay stable until the next accept.
    logic [31:0]         op_pc_q;
    logic                op_store_q;
    logic                op_signed_q;
    logic [1:0]          op_size_q;
    logic [ADDR_W-1:0]   op_addr_q;
    logic [DATA_W-1:0]   op_wdata_q;
    logic                op_gr_we_q;
    logic [4:0]          op_waddr_q;

    logic                out_valid_q, out_valid_d;
    logic [31:0]         out_pc_q, out_pc_d;
    logic                out_gr_we_q, out_gr_we_d;
    logic [4:0]          out_waddr_q, out_waddr_d;
    logic [DATA_W-1:0]   out_wdata_q, out_wdata_d;
    logic                out_ale_q, out_ale_d;
    logic [ADDR_W-1:0]   out_badv_q, out_badv_d;

    logic                accept;
    logic                mis_off;
    logic                in_ale;
    logic                start_req;
    logic [OFF_W-1:0]    off;
    logic [3:0]          nbytes;
    logic [DATA_W-1:0]   lane;
    logic                sign_bit;
    logic                ext;
    logic [DATA_W-1:0]   load_data;
    logic [STRB_W-1:0]   strb;
    logic [DATA_W-1:0]   wdata_rep;

    function automatic logic [DATA_W-1:0] addr_to_data(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] r;
        r = '0;
        r[AX_W-1:0] = a[AX_W-1:0];
        return r;
    endfunction

    assign in_ready  = ~rst & (state_q == S_IDLE) & (~out_valid_q | out_ready) & ~flush;
    assign accept    = in_valid & in_ready;

    // Dword accesses cannot be carried by a 32-bit bus, so they always fault there.
    always_comb begin
        mis_off = 1'b0;
        case (in_size)
            2'd0:    mis_off = 1'b0;
            2'd1:    mis_off = in_addr[0];
            2'd2:    mis_off = |in_addr[1:0];
            default: mis_off = (|in_addr[2:0]) | (DATA_W == 32);
        endcase
        in_ale = in_mem_en & mis_off;
    end

    assign start_req = accept & in_mem_en & ~in_ale;

    assign off    = op_addr_q[OFF_W-1:0];
    assign nbytes = 4'd1 << op_size_q;
    assign lane   = rdata >> {off, 3'b000};

    always_comb begin
        sign_bit = 1'b0;
        case (op_size_q)
            2'd0:    sign_bit = lane[7];
            2'd1:    sign_bit = lane[15];
            2'd2:    sign_bit = lane[31];
            default: sign_bit = lane[DATA_W-1];
        endcase
        ext       = op_signed_q & sign_bit;
        load_data = '0;
        for (int unsigned i = 0; i < STRB_W; i++) begin
            load_data[8*i +: 8] = (i < 32'(nbytes)) ? lane[8*i +: 8] : {8{ext}};
        end
    end

    // Store data: the low 2^size bytes repeat across every lane, so whichever lanes
    // the strobe enables carry the right bytes.
    always_comb begin
        strb      = '0;
        wdata_rep = '0;
        for (int unsigned i = 0; i < STRB_W; i++) begin
            strb[i] = op_store_q & (i >= 32'(off)) & (i < 32'(off) + 32'(nbytes));
            wdata_rep[8*i +: 8] = op_wdata_q[8*(i & (32'(nbytes) - 1)) +: 8];
        end
    end

    always_comb begin
        state_d     = state_q;
        cancel_d    = cancel_q;
        out_valid_d = out_valid_q;
        out_pc_d    = out_pc_q;
        out_gr_we_d = out_gr_we_q;
        out_waddr_d = out_waddr_q;
        out_wdata_d = out_wdata_q;
        out_ale_d   = out_ale_q;
        out_badv_d  = out_badv_q;

        if (out_valid_q & out_ready) begin
            out_valid_d = 1'b0;
        end
        if (flush) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (start_req) begin
                    state_d  = S_REQ;
                    cancel_d = 1'b0;
                end else if (accept) begin
                    out_valid_d = 1'b1;
                    out_pc_d    = in_pc;
                    out_gr_we_d = in_gr_we & ~in_ale;
                    out_waddr_d = in_waddr;
                    out_wdata_d = addr_to_data(in_addr);
                    out_ale_d   = in_ale;
                    out_badv_d  = in_ale ? in_addr : '0;
                end
            end
            // The request must complete its address phase even when flushed;
            // the flush is remembered and applied when the response returns.
            S_REQ: begin
                cancel_d = cancel_q | flush;
                if (addr_ok) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (data_ok) begin
                    state_d  = S_IDLE;
                    cancel_d = 1'b0;
                    if (~cancel_q & ~flush) begin
                        out_valid_d = 1'b1;
                        out_pc_d    = op_pc_q;
                        out_gr_we_d = op_gr_we_q;
                        out_waddr_d = op_waddr_q;
                        out_wdata_d = op_store_q ? addr_to_data(op_addr_q) : load_data;
                        out_ale_d   = 1'b0;
                        out_badv_d  = '0;
                    end
                end else begin
                    cancel_d = cancel_q | flush;
                end
            end
            default: begin
                state_d  = S_IDLE;
                cancel_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cancel_q    <= 1'b0;
            op_pc_q     <= '0;
            op_store_q  <= 1'b0;
            op_signed_q <= 1'b0;
            op_size_q   <= '0;
            op_addr_q   <= '0;
            op_wdata_q  <= '0;
            op_gr_we_q  <= 1'b0;
            op_waddr_q  <= '0;
            out_valid_q <= 1'b0;
            out_pc_q    <= '0;
            out_gr_we_q <= 1'b0;
            out_waddr_q <= '0;
            out_wdata_q <= '0;
            out_ale_q   <= 1'b0;
            out_badv_q  <= '0;
        end else begin
            state_q     <= state_d;
            cancel_q    <= cancel_d;
            out_valid_q <= out_valid_d;
            out_pc_q    <= out_pc_d;
            out_gr_we_q <= out_gr_we_d;
            out_waddr_q <= out_waddr_d;
            out_wdata_q <= out_wdata_d;
            out_ale_q   <= out_ale_d;
            out_badv_q  <= out_badv_d;
            if (start_req) begin
                op_pc_q     <= in_pc;
                op_store_q  <= in_store;
                op_signed_q <= in_signed;
                op_size_q   <= in_size;
                op_addr_q   <= in_addr;
                op_wdata_q  <= in_wdata;
                op_gr_we_q  <= in_gr_we;
                op_waddr_q  <= in_waddr;
            end
        end
    end

    assign req       = (state_q == S_REQ);
    assign req_wr    = op_store_q;
    assign req_size  = op_size_q;
    assign req_addr  = op_addr_q;
    assign req_wstrb = strb;
    assign req_wdata = wdata_rep;

    assign out_valid = out_valid_q;
    assign out_pc    = out_pc_q;
    assign out_gr_we = out_gr_we_q;
    assign out_waddr = out_waddr_q;
    assign out_wdata = out_wdata_q;
    assign out_ale   = out_ale_q;
    assign out_badv  = out_badv_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: instance 0 is DATA_W=32, instance 1 is DATA_W=64.
// Each instance is driven on its own through the indexed signal arrays below.
module tb_mem_access_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic [1:0]      flush, in_valid, in_mem_en, in_store, in_signed, in_gr_we;
    logic [1:0]      addr_ok, data_ok, out_ready;
    logic [1:0][31:0] in_pc, in_addr;
    logic [1:0][1:0] in_size;
    logic [1:0][4:0] in_waddr;
    logic [1:0][63:0] in_wdata, rdata;

    wire [1:0]       in_ready, req, req_wr, out_valid, out_gr_we, out_ale;
    wire [1:0][1:0]  req_size;
    wire [1:0][31:0] req_addr, out_pc, out_badv;
    wire [1:0][4:0]  out_waddr;
    wire [1:0][7:0]  req_wstrb;
    wire [1:0][63:0] req_wdata, out_wdata;
    wire [3:0]       strb32;
    wire [31:0]      rwd32, owd32;

    assign req_wstrb[0] = {4'b0, strb32};
    assign req_wdata[0] = {32'b0, rwd32};
    assign out_wdata[0] = {32'b0, owd32};

    int n_checks = 0;
    int n_errors = 0;

    mem_access_stage #(.DATA_W(32), .ADDR_W(32)) u_dut32 (
        .clk(clk), .rst(rst), .flush(flush[0]),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_pc(in_pc[0]),
        .in_mem_en(in_mem_en[0]), .in_store(in_store[0]), .in_signed(in_signed[0]),
        .in_size(in_size[0]), .in_addr(in_addr[0]), .in_wdata(in_wdata[0][31:0]),
        .in_gr_we(in_gr_we[0]), .in_waddr(in_waddr[0]),
        .req(req[0]), .req_wr(req_wr[0]), .req_size(req_size[0]), .req_addr(req_addr[0]),
        .req_wstrb(strb32), .req_wdata(rwd32),
        .addr_ok(addr_ok[0]), .data_ok(data_ok[0]), .rdata(rdata[0][31:0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_pc(out_pc[0]),
        .out_gr_we(out_gr_we[0]), .out_waddr(out_waddr[0]), .out_wdata(owd32),
        .out_ale(out_ale[0]), .out_badv(out_badv[0])
    );

    mem_access_stage #(.DATA_W(64), .ADDR_W(32)) u_dut64 (
        .clk(clk), .rst(rst), .flush(flush[1]),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_pc(in_pc[1]),
        .in_mem_en(in_mem_en[1]), .in_store(in_store[1]), .in_signed(in_signed[1]),
        .in_size(in_size[1]), .in_addr(in_addr[1]), .in_wdata(in_wdata[1]),
        .in_gr_we(in_gr_we[1]), .in_waddr(in_waddr[1]),
        .req(req[1]), .req_wr(req_wr[1]), .req_size(req_size[1]), .req_addr(req_addr[1]),
        .req_wstrb(req_wstrb[1]), .req_wdata(req_wdata[1]),
        .addr_ok(addr_ok[1]), .data_ok(data_ok[1]), .rdata(rdata[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_pc(out_pc[1]),
        .out_gr_we(out_gr_we[1]), .out_waddr(out_waddr[1]), .out_wdata(out_wdata[1]),
        .out_ale(out_ale[1]), .out_badv(out_badv[1])
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference load extraction: pick the addressed bytes, then extend.
    function automatic logic [63:0] load_val(input logic [63:0] rd, input int dw,
                                             input int off, input int nb, input logic sgn);
        logic [63:0] v, keep;
        v    = (dw == 32) ? (rd & 64'hFFFF_FFFF) : rd;
        v    = v >> (8 * off);
        keep = (nb == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * nb)) - 64'd1);
        v    = v & keep;
        if (sgn && nb < 8 && v[8*nb-1]) v = v | ~keep;
        if (dw == 32) v = v & 64'hFFFF_FFFF;
        return v;
    endfunction

    task automatic step(input int k);
        @(posedge clk);
        @(negedge clk);
        addr_ok[k] = 1'b0;
        data_ok[k] = 1'b0;
        flush[k]   = 1'b0;
        #1;
    endtask

    // One op end to end. fl_mode: 0 none, 1 flush in REQ cycle fl_at,
    // 2 flush in WAIT cycle fl_at, 3 flush in output-hold cycle fl_at.
    task automatic do_op(input int k, input logic mem, input logic st, input logic sgn,
                         input logic [1:0] sz, input logic [31:0] addr, input logic [63:0] wd,
                         input logic [63:0] rd, input logic gwe, input logic [4:0] wa,
                         input int d_addr, input int d_data, input int hold,
                         input int fl_mode, input int fl_at);
        int dw, nb, off, guard;
        logic ale, cancelled, e_gwe;
        logic [31:0] pc;
        logic [63:0] e_wdata, e_strb, e_reqwd;
        dw  = (k == 0) ? 32 : 64;
        nb  = 1 << sz;
        off = int'(addr % (dw / 8));
        ale = mem && (((addr % nb) != 0) || (sz == 2'd3 && dw == 32));
        pc  = $urandom;
        cancelled = 1'b0;
        e_strb  = (st && !ale) ? (((64'd1 << nb) - 64'd1) << off) : 64'd0;
        e_reqwd = 64'd0;
        for (int i = 0; i < dw / 8; i++) e_reqwd[8*i +: 8] = wd[8*(i % nb) +: 8];
        e_gwe   = ale ? 1'b0 : gwe;
        if (!mem || st) e_wdata = {32'b0, addr};
        else if (ale)   e_wdata = 64'd0;
        else            e_wdata = load_val(rd, dw, off, nb, sgn);

        in_valid[k] = 1'b1; in_pc[k] = pc; in_mem_en[k] = mem; in_store[k] = st;
        in_signed[k] = sgn; in_size[k] = sz; in_addr[k] = addr; in_wdata[k] = wd;
        in_gr_we[k] = gwe; in_waddr[k] = wa;
        #1;
        guard = 0;
        while (!in_ready[k] && guard < 20) begin
            step(k);
            guard++;
        end
        check("in_ready_accept", in_ready[k], 1);
        step(k);
        in_valid[k] = 1'b0;
        in_addr[k] = $urandom; in_wdata[k] = {$urandom, $urandom};
        in_size[k] = 2'($urandom); in_store[k] = 1'($urandom); in_pc[k] = $urandom;

        if (mem && !ale) begin
            for (int c = 0; c <= d_addr; c++) begin
                check("req", req[k], 1);
                check("req_wr", req_wr[k], st);
                check("req_size", req_size[k], sz);
                check("req_addr", req_addr[k], addr);
                check("req_wstrb", req_wstrb[k], e_strb);
                if (st) check("req_wdata", req_wdata[k], e_reqwd);
                check("in_ready_req", in_ready[k], 0);
                check("out_valid_req", out_valid[k], 0);
                addr_ok[k] = (c == d_addr);
                if (fl_mode == 1 && fl_at == c) begin
                    flush[k] = 1'b1;
                    cancelled = 1'b1;
                end
                step(k);
            end
            for (int c = 0; c <= d_data; c++) begin
                check("req_wait", req[k], 0);
                check("in_ready_wait", in_ready[k], 0);
                check("out_valid_wait", out_valid[k], 0);
                data_ok[k] = (c == d_data);
                rdata[k]   = (c == d_data) ? rd : {$urandom, $urandom};
                if (fl_mode == 2 && fl_at == c) begin
                    flush[k] = 1'b1;
                    cancelled = 1'b1;
                end
                step(k);
            end
        end else begin
            check("req_none", req[k], 0);
        end

        if (cancelled) begin
            check("out_valid_cancel", out_valid[k], 0);
            check("in_ready_cancel", in_ready[k], 1);
        end else begin
            check("out_valid", out_valid[k], 1);
            check("out_pc", out_pc[k], pc);
            check("out_gr_we", out_gr_we[k], e_gwe);
            check("out_waddr", out_waddr[k], wa);
            if (!ale) check("out_wdata", out_wdata[k], e_wdata);
            check("out_ale", out_ale[k], ale);
            check("out_badv", out_badv[k], ale ? addr : 32'd0);
            for (int h = 0; h < hold; h++) begin
                out_ready[k] = 1'b0;
                if (fl_mode == 3 && fl_at == h) flush[k] = 1'b1;
                step(k);
                if (fl_mode == 3 && fl_at <= h) begin
                    check("out_valid_flushed", out_valid[k], 0);
                    check("in_ready_flushed", in_ready[k], 1);
                end else begin
                    check("out_valid_hold", out_valid[k], 1);
                    check("out_pc_hold", out_pc[k], pc);
                    if (!ale) check("out_wdata_hold", out_wdata[k], e_wdata);
                    check("in_ready_hold", in_ready[k], 0);
                end
            end
            out_ready[k] = 1'b1;
            step(k);
            check("out_valid_drain", out_valid[k], 0);
        end
    endtask

    // Idle cycles with stray handshakes and flushes, which an idle stage ignores.
    task automatic idle_gap(input int k);
        int n;
        n = $urandom_range(2);
        for (int i = 0; i < n; i++) begin
            addr_ok[k] = 1'($urandom);
            data_ok[k] = 1'($urandom);
            flush[k]   = ($urandom_range(3) == 0);
            #1;
            check("in_ready_idle", in_ready[k], !flush[k]);
            check("req_idle", req[k], 0);
            step(k);
            check("out_valid_idle", out_valid[k], 0);
        end
    endtask

    task automatic rand_op(input int k);
        logic mem, st;
        logic [1:0] sz;
        logic [31:0] addr;
        int nb, d_a, d_d, hold, fm, fa;
        mem  = ($urandom_range(3) != 0);
        st   = 1'($urandom_range(1));
        sz   = 2'($urandom_range(3));
        nb   = 1 << sz;
        addr = $urandom;
        if ($urandom_range(4) != 0) addr = addr & ~32'(nb - 1);
        d_a  = $urandom_range(3);
        d_d  = $urandom_range(3);
        hold = $urandom_range(2);
        fm   = $urandom_range(5);
        fa   = 0;
        case (fm)
            1: fa = $urandom_range(d_a);
            2: fa = $urandom_range(d_d);
            3: if (hold == 0) fm = 0; else fa = $urandom_range(hold - 1);
            default: fm = 0;
        endcase
        do_op(k, mem, st, 1'($urandom), sz, addr, {$urandom, $urandom}, {$urandom, $urandom},
              1'($urandom), 5'($urandom), d_a, d_d, hold, fm, fa);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        flush = '0; in_valid = '0; in_mem_en = '0; in_store = '0; in_signed = '0;
        in_gr_we = '0; addr_ok = '0; data_ok = '0; out_ready = '1;
        in_pc = '0; in_addr = '0; in_size = '0; in_waddr = '0; in_wdata = '0; rdata = '0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check("rst_in_ready", in_ready[k], 0);
            check("rst_req", req[k], 0);
            check("rst_req_wstrb", req_wstrb[k], 0);
            check("rst_req_addr", req_addr[k], 0);
            check("rst_out_valid", out_valid[k], 0);
            check("rst_out_wdata", out_wdata[k], 0);
            check("rst_out_badv", out_badv[k], 0);
        end
        rst = 1'b0;
        step(0);

        do_op(0, 1, 0, 1, 2'd0, 32'h1003, 64'h0, 64'h8011_2233, 1, 5'd3, 0, 0, 0, 0, 0);
        do_op(0, 1, 1, 0, 2'd1, 32'h1002, 64'h0000_ABCD, 64'h0, 0, 5'd0, 0, 0, 0, 0, 0);
        do_op(0, 1, 0, 0, 2'd2, 32'h1000, 64'h0, 64'hCAFE_F00D, 1, 5'd7, 4, 0, 0, 0, 0);
        do_op(0, 1, 0, 0, 2'd2, 32'h1001, 64'h0, 64'h0, 1, 5'd8, 0, 0, 1, 0, 0);
        do_op(0, 1, 0, 0, 2'd2, 32'h1004, 64'h0, 64'h1234_5678, 1, 5'd9, 0, 2, 0, 2, 0);
        do_op(0, 1, 0, 0, 2'd1, 32'h2006, 64'h0, 64'h8765_4321, 1, 5'd10, 1, 1, 0, 1, 1);
        do_op(0, 1, 0, 1, 2'd1, 32'h2006, 64'h0, 64'h8765_4321, 1, 5'd11, 1, 1, 0, 2, 1);
        do_op(0, 1, 0, 0, 2'd3, 32'h3000, 64'h0, 64'h0, 1, 5'd12, 0, 0, 0, 0, 0);
        do_op(0, 0, 0, 0, 2'd2, 32'h3003, 64'h0, 64'h0, 1, 5'd13, 0, 0, 2, 3, 1);
        do_op(1, 1, 0, 0, 2'd3, 32'h0000_0008, 64'h0, 64'h8000_0000_0000_0001, 1, 5'd4, 0, 0, 3, 0, 0);
        do_op(1, 1, 1, 0, 2'd2, 32'h0000_0014, 64'h1122_3344_5566_7788, 64'h0, 0, 5'd5, 0, 1, 0, 0, 0);
        do_op(1, 1, 0, 1, 2'd0, 32'h0000_0015, 64'h0, 64'h0011_2233_4455_F677, 1, 5'd6, 2, 0, 0, 0, 0);

        for (int k = 0; k < 2; k++) begin
            for (int n = 0; n < 150; n++) begin
                idle_gap(k);
                rand_op(k);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
